// File: rtl/mcu_spi_arbiter.sv
// mcu_spi_arbiter: round-robin owner of the MCU SPI link with post-transaction guard gap and stretch watchdog
module mcu_spi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GUARD_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               SClk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Grant,
  input  logic [NUM_REQ-1:0] ReqnSel,
  input  logic [NUM_REQ-1:0] ReqDo,
  input  logic [NUM_REQ-1:0] ReqClkRunning,
  input  logic [NUM_REQ-1:0] ReqClkStretch,
  input  logic               MCUReadyFallingEdge,
  output logic [NUM_REQ-1:0] ReqReadyFallingEdge,
  output logic [NUM_REQ-1:0] Abort,
  output logic               nMCUSel,
  output logic               SPIDo,
  output logic               SPIClkRunning,
  output logic               SPIClkStretch,
  output logic               Busy,
  output logic               TimeoutErr,
  input  logic               ClearErr
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = GUARD_CYCLES > 2 ? $clog2(GUARD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE, GUARD} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] last, pick, j;
  logic found, link, tmo, guard_done;
  logic [CW-1:0] wdog, wdog_nxt;
  logic [GW-1:0] gcnt;
  assign link = state == GRANTED || state == ACTIVE;
  assign nMCUSel = link ? ReqnSel[last] : 1'b1;
  assign SPIDo = link ? ReqDo[last] : 1'b1;
  assign SPIClkRunning = link ? ReqClkRunning[last] : 1'b0;
  assign SPIClkStretch = link ? ReqClkStretch[last] : 1'b0;
  assign ReqReadyFallingEdge = link ? Grant & {NUM_REQ{MCUReadyFallingEdge}} : '0;
  assign Busy = state != IDLE;
  assign wdog_nxt = ReqClkStretch[last] ? wdog + 1'b1 : '0;
  assign tmo = TIMEOUT_CYCLES != 0 && state == ACTIVE && ReqClkStretch[last] && wdog_nxt == CW'(TIMEOUT_CYCLES);
  assign guard_done = GUARD_CYCLES <= 1 || gcnt == GW'(GUARD_CYCLES - 1);
  // search upward starting just after the most recently granted engine
  always_comb begin
    pick = last;
    found = 1'b0;
    j = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = IW'((int'(last) + i) % NUM_REQ);
      if (!found && Req[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = |Req ? GRANTED : IDLE;
      GRANTED: state_nxt = !ReqnSel[last] ? ACTIVE : (!Req[last] ? IDLE : GRANTED);
      ACTIVE:  state_nxt = tmo || ReqnSel[last] ? GUARD : ACTIVE;
      GUARD:   state_nxt = guard_done ? IDLE : GUARD;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge SClk) begin
    if (Reset) begin
      state <= IDLE;
      Grant <= '0;
      Abort <= '0;
      TimeoutErr <= 1'b0;
      last <= IW'(NUM_REQ - 1);
      wdog <= '0;
      gcnt <= '0;
    end else begin
      state <= state_nxt;
      Abort <= tmo ? NUM_REQ'(1) << last : '0;
      TimeoutErr <= tmo | (TimeoutErr & ~ClearErr);
      wdog <= state == ACTIVE ? wdog_nxt : '0;
      gcnt <= state == GUARD ? gcnt + 1'b1 : '0;
      if (state == IDLE && |Req) begin
        Grant <= NUM_REQ'(1) << pick;
        last <= pick;
      end else if (state_nxt == IDLE || state_nxt == GUARD) begin
        Grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// tb_mcu_spi_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_mcu_spi_arbiter;
  localparam int N = 2;
  localparam int G = 8;
  localparam int T = 16;
  logic SClk = 1'b0;
  logic Reset, MCUReadyFallingEdge, ClearErr;
  logic [N-1:0] Req, ReqnSel, ReqDo, ReqClkRunning, ReqClkStretch;
  logic [N-1:0] Grant, ReqReadyFallingEdge, Abort;
  logic nMCUSel, SPIDo, SPIClkRunning, SPIClkStretch, Busy, TimeoutErr;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_owner = -1;
  int m_guard = 0;
  int m_run = 0;
  int m_last = N - 1;
  bit m_started = 0;
  bit m_err = 0;
  bit m_tmo = 0;
  logic [N-1:0] m_abort = '0;
  logic [N-1:0] e_grant, e_rrfe;
  logic e_nsel, e_do, e_run, e_str, e_busy;
  logic [3*N+5:0] obs, exp_v;

  mcu_spi_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .SClk(SClk), .Reset(Reset), .Req(Req), .Grant(Grant), .ReqnSel(ReqnSel), .ReqDo(ReqDo),
    .ReqClkRunning(ReqClkRunning), .ReqClkStretch(ReqClkStretch),
    .MCUReadyFallingEdge(MCUReadyFallingEdge), .ReqReadyFallingEdge(ReqReadyFallingEdge),
    .Abort(Abort), .nMCUSel(nMCUSel), .SPIDo(SPIDo), .SPIClkRunning(SPIClkRunning),
    .SPIClkStretch(SPIClkStretch), .Busy(Busy), .TimeoutErr(TimeoutErr), .ClearErr(ClearErr)
  );

  always #5 SClk = ~SClk;

  // Model: who owns the link, whether their chip-select has opened, guard cycles left
  always @(posedge SClk) begin
    m_abort = '0;
    m_tmo = 0;
    if (Reset) begin
      m_owner = -1; m_started = 0; m_guard = 0; m_run = 0; m_last = N - 1; m_err = 0;
    end else begin
      if (m_guard > 0) m_guard--;
      else if (m_owner < 0) begin
        for (int i = 1; i <= N; i++)
          if (Req[(m_last + i) % N]) begin
            m_owner = (m_last + i) % N; m_last = m_owner; m_started = 0;
            break;
          end
      end else if (!m_started) begin
        if (!ReqnSel[m_owner]) begin m_started = 1; m_run = 0; end
        else if (!Req[m_owner]) m_owner = -1;
      end else begin
        m_run = ReqClkStretch[m_owner] ? m_run + 1 : 0;
        if (T > 0 && m_run == T) begin
          m_tmo = 1; m_abort[m_owner] = 1'b1; m_owner = -1; m_guard = G;
        end else if (ReqnSel[m_owner]) begin
          m_owner = -1; m_guard = G;
        end
      end
      m_err = m_tmo | (m_err & !ClearErr);
    end
  end

  always_comb begin
    e_grant = m_owner >= 0 ? N'(1) << m_owner : '0;
    e_nsel = m_owner >= 0 ? ReqnSel[m_owner] : 1'b1;
    e_do = m_owner >= 0 ? ReqDo[m_owner] : 1'b1;
    e_run = m_owner >= 0 ? ReqClkRunning[m_owner] : 1'b0;
    e_str = m_owner >= 0 ? ReqClkStretch[m_owner] : 1'b0;
    e_rrfe = MCUReadyFallingEdge ? e_grant : '0;
    e_busy = m_owner >= 0 || m_guard > 0;
    exp_v = {e_grant, m_abort, e_rrfe, e_nsel, e_do, e_run, e_str, e_busy, m_err};
  end
  assign obs = {Grant, Abort, ReqReadyFallingEdge, nMCUSel, SPIDo, SPIClkRunning, SPIClkStretch, Busy, TimeoutErr};

  task automatic tick();
    @(posedge SClk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    Reset = 0; Req = '0; ReqnSel = '1; ReqDo = '0; ReqClkRunning = '0; ReqClkStretch = '0;
    MCUReadyFallingEdge = 0; ClearErr = 0;
  endtask

  task automatic settle();
    idle_inputs();
    for (int w = 0; w < 60 && Busy !== 1'b0; w++) tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1; Req = '1; ReqnSel = '0; ReqClkRunning = '1; ReqClkStretch = '1;
    tick(); tick();
    checks++;
    if (obs !== {2'b00, 2'b00, 2'b00, 6'b110000}) begin errors++; $display("FAIL reset_values got=%b exp=%b", obs, {2'b00, 2'b00, 2'b00, 6'b110000}); end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_model got=%b exp=%b", obs, exp_v); end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    Req = 2'b01;
    tick();
    checks++;
    if (Grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", Grant); end
    tick(); tick();
    ReqnSel = 2'b10;
    #1;
    checks++;
    if (nMCUSel !== 1'b0) begin errors++; $display("FAIL single_nsel_low got=%b exp=0", nMCUSel); end
    repeat (17) tick();
    ReqnSel = 2'b11; Req = 2'b00;
    tick();
    checks++;
    if ({Grant, nMCUSel, Busy} !== 4'b0011) begin errors++; $display("FAIL single_release got=%b exp=0011", {Grant, nMCUSel, Busy}); end
    for (int c = 22; c <= 28; c++) begin
      tick();
      checks++;
      if ({nMCUSel, Busy} !== 2'b11) begin errors++; $display("FAIL single_guard cyc=%0d got=%b exp=11", c, {nMCUSel, Busy}); end
    end
    tick();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", Busy); end
    settle();
  endtask

  task automatic test_round_robin();
    int rel;
    int w;
    rel = 0;
    Reset = 1; tick(); Reset = 0;
    Req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (Grant === '0 && w < 40) begin tick(); w++; end
      checks++;
      if (Grant !== ((k % 2 != 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, Grant, (k % 2 != 0) ? 2'b10 : 2'b01); end
      if (k > 0) begin
        checks++;
        if (cyc - rel != 10) begin errors++; $display("FAIL rr_gap k=%0d got=%0d exp=10", k, cyc - rel); end
      end
      ReqnSel = ~Grant;
      repeat (10) tick();
      ReqnSel = '1;
      rel = cyc;
      tick();
    end
    settle();
  endtask

  task automatic test_abandon();
    Req = 2'b10;
    tick();
    checks++;
    if ({Grant, nMCUSel} !== 3'b101) begin errors++; $display("FAIL abandon_grant got=%b exp=101", {Grant, nMCUSel}); end
    tick(); tick();
    Req = 2'b00;
    #1;
    checks++;
    if (nMCUSel !== 1'b1) begin errors++; $display("FAIL abandon_nsel got=%b exp=1", nMCUSel); end
    tick();
    checks++;
    if ({Grant, Busy, nMCUSel} !== 4'b0001) begin errors++; $display("FAIL abandon_idle got=%b exp=0001", {Grant, Busy, nMCUSel}); end
    settle();
  endtask

  task automatic test_timeout();
    Req = 2'b01;
    tick();
    ReqnSel = 2'b10; ReqClkStretch = 2'b01;
    for (int c = 2; c <= 17; c++) begin
      tick();
      if (c == 17) ClearErr = 1;
      checks++;
      if ({Abort, TimeoutErr} !== 3'b000) begin errors++; $display("FAIL timeout_early cyc=%0d got=%b exp=000", c, {Abort, TimeoutErr}); end
    end
    tick();
    checks++;
    if ({Abort, TimeoutErr, nMCUSel, Grant, Busy} !== 7'b0111001) begin errors++; $display("FAIL timeout_abort got=%b exp=0111001", {Abort, TimeoutErr, nMCUSel, Grant, Busy}); end
    ClearErr = 0; ReqnSel = '1; Req = '0; ReqClkStretch = '0;
    tick();
    checks++;
    if ({Abort, TimeoutErr} !== 3'b001) begin errors++; $display("FAIL timeout_pulse got=%b exp=001", {Abort, TimeoutErr}); end
    ClearErr = 1;
    tick();
    checks++;
    if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", TimeoutErr); end
    settle();
    Req = 2'b01;
    tick();
    ReqnSel = 2'b10;
    for (int i = 0; i < 40; i++) begin
      ReqClkStretch = (i % 10 == 9) ? 2'b00 : 2'b01;
      tick();
      checks++;
      if ({Abort, TimeoutErr} !== 3'b000) begin errors++; $display("FAIL timeout_noabort i=%0d got=%b exp=000", i, {Abort, TimeoutErr}); end
    end
    settle();
  endtask

  task automatic test_strobe();
    Req = 2'b10;
    tick();
    ReqnSel = 2'b01;
    tick(); tick();
    MCUReadyFallingEdge = 1;
    #1;
    checks++;
    if (ReqReadyFallingEdge !== 2'b10) begin errors++; $display("FAIL strobe_active got=%b exp=10", ReqReadyFallingEdge); end
    MCUReadyFallingEdge = 0;
    tick();
    ReqnSel = '1; Req = '0;
    tick();
    MCUReadyFallingEdge = 1;
    #1;
    checks++;
    if ({ReqReadyFallingEdge, Busy} !== 3'b001) begin errors++; $display("FAIL strobe_guard got=%b exp=001", {ReqReadyFallingEdge, Busy}); end
    settle();
    MCUReadyFallingEdge = 1;
    #1;
    checks++;
    if (ReqReadyFallingEdge !== 2'b00) begin errors++; $display("FAIL strobe_idle got=%b exp=00", ReqReadyFallingEdge); end
    settle();
  endtask

  task automatic test_reset_mid();
    Req = 2'b01;
    tick();
    ReqnSel = 2'b10; ReqClkRunning = 2'b01;
    tick(); tick();
    checks++;
    if ({nMCUSel, SPIClkRunning} !== 2'b01) begin errors++; $display("FAIL rstmid_active got=%b exp=01", {nMCUSel, SPIClkRunning}); end
    Reset = 1;
    tick();
    checks++;
    if ({Grant, nMCUSel, SPIClkRunning, Abort, Busy} !== 7'b0010000) begin errors++; $display("FAIL rstmid_after got=%b exp=0010000", {Grant, nMCUSel, SPIClkRunning, Abort, Busy}); end
    Reset = 0; Req = 2'b11; ReqnSel = '1; ReqClkRunning = '0;
    tick();
    checks++;
    if (Grant !== 2'b01) begin errors++; $display("FAIL rstmid_regrant got=%b exp=01", Grant); end
    settle();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 2500; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) Req[b] = ~Req[b];
        if ($urandom_range(0, 7) == 0) ReqnSel[b] = ~ReqnSel[b];
        ReqDo[b] = 1'($urandom_range(0, 1));
        ReqClkRunning[b] = 1'($urandom_range(0, 1));
        ReqClkStretch[b] = $urandom_range(0, 15) != 0;
      end
      MCUReadyFallingEdge = $urandom_range(0, 3) == 0;
      ClearErr = $urandom_range(0, 15) == 0;
      #1;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v); end
      tick();
    end
    settle();
  endtask

  initial begin
    idle_inputs();
    Reset = 1;
    test_reset();
    test_single();
    test_round_robin();
    test_abandon();
    test_timeout();
    test_strobe();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcu_spi_arbiter.md
Name: mcu_spi_arbiter

Overview:
Shares the single MCU SPI link (nMCUSel, SPIDo, clock run/stretch controls, ready-falling-edge strobe) between NUM_REQ SPI master engines, e.g. the RTC command engine and the cartridge SPI/save engine. Grants are round-robin. A grant lasts for one whole chip-select transaction and is followed by a guaranteed deselect guard gap. A watchdog aborts transactions stuck in clock-stretch waiting for the MCU.

Parameters:
NUM_REQ, 2, number of requesting engines (2..4); index 0 = RTC engine
GUARD_CYCLES, 8, SClk cycles nMCUSel is held high after a transaction before the next grant
TIMEOUT_CYCLES, 4096, consecutive stretch cycles before abort; 0 disables the watchdog

Ports:
SClk  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
Req  in  NUM_REQ  per-engine request level
Grant  out  NUM_REQ  one-hot grant, registered
ReqnSel  in  NUM_REQ  per-engine chip select, active low
ReqDo  in  NUM_REQ  per-engine MOSI bit
ReqClkRunning  in  NUM_REQ  per-engine SPI clock-run request
ReqClkStretch  in  NUM_REQ  per-engine clock-stretch request
MCUReadyFallingEdge  in  1  one-cycle strobe from the MCU ready synchroniser
ReqReadyFallingEdge  out  NUM_REQ  strobe forwarded to the granted engine only
Abort  out  NUM_REQ  one-cycle pulse to an engine whose transaction timed out
nMCUSel  out  1  MCU chip select to pin logic
SPIDo  out  1  MOSI to pin logic
SPIClkRunning  out  1  to SPI clock generator
SPIClkStretch  out  1  to SPI clock generator
Busy  out  1  high in any state other than Idle
TimeoutErr  out  1  sticky; set on abort
ClearErr  in  1  clears TimeoutErr

Behaviour:
- State machine: Idle, Granted, Active, Guard. Reset forces Idle.
- Reset values: Grant=0, Abort=0, ReqReadyFallingEdge=0, nMCUSel=1, SPIDo=1, SPIClkRunning=0, SPIClkStretch=0, Busy=0, TimeoutErr=0. The round-robin pointer is reset so requester 0 has highest priority.
- Idle: if any Req bit is high, select the first set bit searching upward from (last granted + 1) modulo NUM_REQ. On the next edge, Grant becomes that one-hot value and the state moves to Granted. Req high at cycle N gives Grant at cycle N+1.
- Granted: link outputs are combinational muxes of the granted engine's ReqnSel, ReqDo, ReqClkRunning and ReqClkStretch. When the granted ReqnSel is sampled 0, go to Active. If the granted Req drops while ReqnSel is still 1, clear Grant and return to Idle with no guard gap; the pointer is still updated.
- Active: same muxing. The engine's Req level is ignored. The transaction ends when the granted ReqnSel is sampled 1; then clear Grant and go to Guard.
- Watchdog (Active only): the counter increments each cycle the granted ReqClkStretch=1 and clears to 0 when it is 0. When the count reaches TIMEOUT_CYCLES:
  - pulse Abort[g] for one cycle;
  - set TimeoutErr;
  - clear Grant and go to Guard.
  - From that edge on, nMCUSel=1 regardless of the engine.
  - The counter width is clog2(TIMEOUT_CYCLES+1).
- Guard: nMCUSel=1, SPIDo=1, clocks off. Count GUARD_CYCLES cycles, then go to Idle. Requests arriving during Guard are held pending, not granted.
- Outside Granted/Active: nMCUSel=1, SPIDo=1, SPIClkRunning=0, SPIClkStretch=0, irrespective of the engine inputs.
- ReqReadyFallingEdge[g] = MCUReadyFallingEdge & Grant[g] while in Granted/Active. Strobes arriving in Idle or Guard are dropped.
- Non-granted engines' inputs have no effect on the link.
- ClearErr together with a new timeout in the same cycle: set wins.
- Reset asserted mid-transaction: the next edge gives Idle, nMCUSel=1, Grant=0, and no Abort pulse.

Test Plan:
- Single request: Req=01 at cycle 0 -> Grant=01 at cycle 1; ReqnSel[0] low at cycle 3 -> nMCUSel low same cycle; ReqnSel[0] high at cycle 20 -> Grant=00 at 21, nMCUSel high for 8 cycles, Busy low at 29.
- Round-robin: Req=11 continuously, each transaction 10 cycles -> grants alternate 01,10,01,10; the second grant is not earlier than 8 cycles after the first release.
- Abandoned grant: Req[1] rises, then falls at Granted+2 with ReqnSel[1] still 1 -> Idle the next cycle, no guard, nMCUSel never low.
- Timeout (TIMEOUT_CYCLES=16): the granted engine holds ReqClkStretch=1 with no ready strobe -> Abort[g] pulses on the 16th stretch cycle, TimeoutErr=1, nMCUSel=1 next cycle. ClearErr clears TimeoutErr. Stretch with a 1-cycle drop every 10 cycles -> no abort.
- Strobe steering: MCUReadyFallingEdge pulses during Active(Grant=10) -> only ReqReadyFallingEdge[1]; a pulse during Guard -> none.
- Reset mid-Active: Reset high for 1 cycle -> Grant=0, nMCUSel=1, SPIClkRunning=0 the following cycle; Req=11 afterwards -> Grant=01 first.
